// File: rtl/handshake_constant_burst.sv
// handshake_constant_burst
//   Each accepted control token starts a burst of REPEAT output tokens.
//   MODE 0 repeats VALUE. MODE 1 emits the ramp VALUE, VALUE+STEP, ...,
//   which wraps modulo 2^DATA_WIDTH.
//   outs, outs_valid and outs_last are registered. The only combinational
//   input-to-output path is outs_ready -> ctrl_ready.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   ctrl_valid   control token offered
//   ctrl_ready   control token accepted when ctrl_valid && ctrl_ready
//   outs         emitted data; holds its last value while idle
//   outs_valid   output token valid
//   outs_ready   consumer ready
//   outs_last    marks the final token of a burst
module handshake_constant_burst #(
  parameter int unsigned                DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0]      VALUE      = 16'h43E2,
  parameter int unsigned                REPEAT     = 1,
  parameter int unsigned                MODE       = 0,
  parameter logic [DATA_WIDTH-1:0]      STEP       = DATA_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_last
);

  localparam int unsigned CW = $clog2(REPEAT + 1);

  if (REPEAT < 1 || REPEAT > 65535) begin : g_bad_repeat
    $error("handshake_constant_burst: REPEAT must be in 1..65535");
  end

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  outs_valid_q, outs_valid_d;
  logic                  outs_last_q, outs_last_d;
  logic                  last_beat;

  assign last_beat  = (remaining_q == CW'(1));
  assign ctrl_ready = (state_q == IDLE) || (state_q == EMIT && last_beat && outs_ready);

  assign outs       = data_q;
  assign outs_valid = outs_valid_q;
  assign outs_last  = outs_last_q;

  // outs_valid is always high in EMIT, so a fire is just outs_ready there.
  // outs_last is precomputed from the next remaining count so that it is a
  // plain register output.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    data_d       = data_q;
    outs_valid_d = outs_valid_q;
    outs_last_d  = outs_last_q;
    case (state_q)
      IDLE: begin
        if (ctrl_valid) begin
          state_d      = EMIT;
          remaining_d  = CW'(REPEAT);
          data_d       = VALUE;
          outs_valid_d = 1'b1;
          outs_last_d  = (REPEAT == 1);
        end
      end
      EMIT: begin
        if (outs_ready) begin
          if (!last_beat) begin
            remaining_d = remaining_q - CW'(1);
            if (MODE == 1) data_d = data_q + STEP;
            outs_last_d = (32'(remaining_q) == 32'd2);
          end else if (ctrl_valid) begin
            remaining_d = CW'(REPEAT);
            data_d      = VALUE;
            outs_last_d = (REPEAT == 1);
          end else begin
            state_d      = IDLE;
            outs_valid_d = 1'b0;
            outs_last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      data_q       <= VALUE;
      outs_valid_q <= 1'b0;
      outs_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      data_q       <= data_d;
      outs_valid_q <= outs_valid_d;
      outs_last_q  <= outs_last_d;
    end
  end

endmodule

// File: tb/tb_handshake_constant_burst.sv
module tb_handshake_constant_burst;

  localparam int unsigned DW      = 16;
  localparam logic [15:0] P_VALUE = 16'h0001;
  localparam logic [15:0] P_STEP  = 16'hFFFF;
  localparam int unsigned P_REP   = 3;
  localparam int unsigned P_MODE  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ctrl_valid = 1'b0;
  logic          ctrl_ready;
  logic [DW-1:0] outs;
  logic          outs_valid;
  logic          outs_ready = 1'b0;
  logic          outs_last;

  handshake_constant_burst #(
    .DATA_WIDTH(DW),
    .VALUE     (P_VALUE),
    .REPEAT    (P_REP),
    .MODE      (P_MODE),
    .STEP      (P_STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready),
    .outs      (outs),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready),
    .outs_last (outs_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: the k-th token of a burst is VALUE + k*STEP (mod 2^DW) in ramp
  // mode, VALUE otherwise; the final token carries last.
  function automatic void push_burst();
    exp_t t;
    for (int unsigned k = 0; k < P_REP; k++) begin
      t.data = (P_MODE == 1) ? DW'(32'(P_VALUE) + k * 32'(P_STEP)) : P_VALUE;
      t.last = (k == P_REP - 1);
      exp_q.push_back(t);
    end
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  logic          rst_prev = 1'b0;
  logic          stall_v = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy;
    if (rst) begin
      if (rst_prev) begin
        check("rst_outs_valid", 32'(outs_valid), 32'd0);
        check("rst_ctrl_ready", 32'(ctrl_ready), 32'd1);
        check("rst_outs", 32'(outs), 32'(P_VALUE));
        check("rst_outs_last", 32'(outs_last), 32'd0);
      end
      exp_q.delete();
      stall_v = 1'b0;
    end else begin
      check("outs_valid", 32'(outs_valid), 32'(exp_q.size() != 0));
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && outs_ready);
      check("ctrl_ready", 32'(ctrl_ready), 32'(exp_rdy));
      if (stall_v) begin
        check("stall_outs", 32'(outs), 32'(stall_data));
        check("stall_last", 32'(outs_last), 32'(stall_last));
      end
      stall_v    = outs_valid && !outs_ready;
      stall_data = outs;
      stall_last = outs_last;
      if (outs_valid && outs_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("outs", 32'(outs), 32'(e.data));
        check("outs_last", 32'(outs_last), 32'(e.last));
      end
      if (ctrl_valid && ctrl_ready) push_burst();
    end
    rst_prev = rst;
  end

  // One stimulus cycle: a pending ctrl token is held until accepted;
  // otherwise ctrl_valid / outs_ready are drawn with the given % odds.
  task automatic step(input int pc, input int pr);
    logic acc;
    @(negedge clk);
    acc = ctrl_valid && ctrl_ready && !rst;
    @(posedge clk);
    #1;
    if (!(ctrl_valid && !acc)) ctrl_valid = ($urandom_range(0, 99) < pc);
    outs_ready = ($urandom_range(0, 99) < pr);
  endtask

  initial begin
    int waited;
    // Reset with a pending control token.
    rst = 1'b1;
    ctrl_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    outs_ready = 1'b1;

    // Back-to-back: continuous ctrl and ready, no bubbles expected.
    repeat (20) step(100, 100);

    // Backpressure: ready low for several cycles mid-burst.
    repeat (2) step(100, 100);
    repeat (5) step(100, 0);
    repeat (6) step(100, 100);

    // Random traffic.
    repeat (400) step(60, 60);

    // Reset mid-burst.
    waited = 0;
    while (!(outs_valid && !outs_last) && waited < 50) begin
      step(100, 100);
      waited++;
    end
    #1 rst = 1'b1;
    ctrl_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) step(100, 100);
    repeat (300) step(50, 70);

    // Drain.
    @(posedge clk);
    #1;
    waited = 0;
    while ((ctrl_valid || exp_q.size() != 0) && waited < 50) begin
      @(posedge clk);
      #1;
      if (ctrl_valid && ctrl_ready) ctrl_valid = 1'b0;
      outs_ready = 1'b1;
      waited++;
    end
    if (waited >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d tokens outstanding, expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
